elastic_pipeline: RTL
=====================

// Module: elastic_pipeline
// PURPOSE
//  Parametrised N-stage pipeline register chain with valid/ready backpressure, per-stage flush and bubble collapsing.
//  Successor to the fixed IF/ID/EX/MEM/WB registers: one instance per datapath lane replaces hand-written stage regs.
//  Carries an opaque payload; stalls propagate backwards only as far as the nearest empty stage.
// PARAMETERS
//  WIDTH   32  payload bits per stage
//  STAGES  5   number of register stages (>=1); stage 0 = entry, stage STAGES-1 = exit
// PORTS
//  clk        in   1             rising-edge clock
//  reset_n    in   1             reset, synchronous, active-low
//  in_valid   in   1             producer offers in_data
//  in_ready   out  1             chain accepts in_data this cycle
//  in_data    in   WIDTH         payload in
//  out_valid  out  1             exit stage holds a valid item
//  out_ready  in   1             consumer accepts out_data this cycle
//  out_data   out  WIDTH         payload out (exit stage register)
//  flush      in   STAGES        bit i invalidates stage i (e.g. younger-than-branch kill)
//  occupancy  out  $clog2(STAGES+2)  count of valid entries (stages + skid entry if present)
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): all valid bits 0, all data regs 0 -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  - Per stage i: ready[i] = !valid_q[i] | ready[i+1]; ready[STAGES] = out_ready. in_ready = ready[0] (no skid).
//  - When ready[i]: stage i loads valid/data from stage i-1 (stage 0 from in_valid/in_data). Otherwise holds.
//  - Transfer on input when in_valid & in_ready; on output when out_valid & out_ready. Data never duplicated or dropped except by flush.
//  - Latency: empty chain, item accepted at edge k -> out_valid at edge k+STAGES-1 visible (STAGES cycles in->out). Throughput 1/cycle.
//  - Bubble collapsing: with out_ready=0, upstream items keep advancing until they abut the stalled one.
//  - flush[i]=1: valid_q[i] <= 0 at next edge, overriding any load into stage i (the incoming item is discarded).
//  - ready[] is computed from pre-flush valid_q; flush has no combinational path to in_ready/out_valid.
//  - flush[STAGES-1] with out_valid & out_ready same cycle: output transfer still counts; stage empties.
//  - flush[0] with input transfer same cycle: input item is accepted and discarded.
//  - occupancy = popcount of registered valid bits (+ skid valid); updated every edge.
//  - Reset mid-stream: all in-flight items lost; no output transfer reported on reset cycle.
// CONFIGURATION
//  ELASTIC_PIPELINE_SKID_EN defined: a 1-entry skid buffer sits before stage 0.
//   in_ready = !skid_valid (registered, no comb path from out_ready).
//   Accepted item goes straight into stage 0 when ready[0] and skid empty, else into skid; skid drains to stage 0 first when ready[0].
//   flush[0] also clears skid. Latency unchanged when skid empty; occupancy counts skid entry.
//  Undefined: no skid; in_ready = ready[0] (combinational chain from out_ready); occupancy max = STAGES.
// STRUCTURE
//  common package: localparam WORD_W=32, PIPE_STAGES=5 (defaults for CPU lanes).
//  Sub-module pipe_slot #(WIDTH): one stage (valid_q, data_q, load, flush, sync reset); generated STAGES times.
//  Ready chain, skid logic and occupancy popcount live in elastic_pipeline.
// TESTING
//  1 Reset then idle: out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  2 STAGES=5, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> same values exit in order, first 5 cycles after accept, back-to-back.
//  3 out_ready=0, push 7 items into 5 stages -> 5 accepted, in_ready=0 after 5th, occupancy=5; release out_ready -> 0x..1..5 in order, no loss.
//  4 Fill 5 stages, assert flush=5'b00111 one cycle -> occupancy=2, only items in stages 3,4 emerge.
//  5 Bubble: items at stages 0 and 2, out_ready=0 -> next cycle stage-0 item advances to stage 1; stage 2 item holds.
//  6 ELASTIC_PIPELINE_SKID_EN: full chain, out_ready=0, in_valid=1 -> one extra item absorbed (occupancy=6), in_ready=0 next cycle; flush[0] clears skid.

Source files
------------

// File: rtl/elastic_pipeline_pkg.sv
// Shared constants for elastic pipeline lanes.
// Default lane geometry matches the CPU datapath (32-bit payload, five stages).

package elastic_pipeline_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned PIPE_STAGES = 5;

    // Occupancy counter width: room for every stage plus an optional skid entry.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// Valid/ready handshake bundle for one elastic pipeline lane.
// master: producer/consumer side; slave: the pipeline itself.

interface elastic_pipeline_if
    import elastic_pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/elastic_pipeline_pipe_slot.sv
// One register stage of the elastic pipeline: valid bit plus payload.
// Flush wins over load; payload only updates when a valid item arrives.

module pipe_slot
    import elastic_pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Stage register: load from upstream when allowed, kill on flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (load) begin
                valid <= src_valid;
                if (src_valid) begin
                    data <= src_data;
                end
            end
            if (flush) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// Parametrised elastic register chain with valid/ready backpressure,
// per-stage flush and bubble collapsing.
// Optional feature: define ELASTIC_PIPELINE_SKID_EN to add a 1-entry skid
// buffer in front of stage 0, which registers in_ready.

module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned STAGES = PIPE_STAGES
) (
    input  logic                        clk,
    input  logic                        reset_n,
    elastic_pipeline_if.slave           pipe,
    input  logic [STAGES-1:0]           flush,
    output logic [$clog2(STAGES+2)-1:0] occupancy
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] ready;
    logic              src_valid;
    logic [WIDTH-1:0]  src_data;
    logic              skid_occ;

    // Ready chain from the exit backwards; a stage can move if it is empty or
    // everything downstream of it can move. Uses pre-flush valid bits only.
    always_comb begin
        logic r;
        r     = pipe.out_ready;
        ready = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            r        = r | ~valid_q[i];
            ready[i] = r;
        end
    end

`ifdef ELASTIC_PIPELINE_SKID_EN
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             accept;

    // in_ready depends only on the skid register, cutting the out_ready path.
    assign pipe.in_ready = ~skid_valid_q;
    assign accept        = pipe.in_valid & ~skid_valid_q;
    // A parked item always goes to stage 0 before any newer input.
    assign src_valid     = skid_valid_q | pipe.in_valid;
    assign src_data      = skid_valid_q ? skid_data_q : pipe.in_data;
    assign skid_occ      = skid_valid_q;

    // Skid entry: park an accepted item stage 0 cannot take, drain when it can.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (flush[0]) begin
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (ready[0]) begin
                skid_valid_q <= 1'b0;
            end
        end else if (accept && !ready[0]) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= pipe.in_data;
        end
    end
`else
    assign pipe.in_ready = ready[0];
    assign src_valid     = pipe.in_valid;
    assign src_data      = pipe.in_data;
    assign skid_occ      = 1'b0;
`endif

    for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
        logic             slot_src_valid;
        logic [WIDTH-1:0] slot_src_data;

        if (i == 0) begin : g_head
            assign slot_src_valid = src_valid;
            assign slot_src_data  = src_data;
        end else begin : g_body
            assign slot_src_valid = valid_q[i-1];
            assign slot_src_data  = data_q[i-1];
        end

        pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (ready[i]),
            .flush     (flush[i]),
            .src_valid (slot_src_valid),
            .src_data  (slot_src_data),
            .valid     (valid_q[i]),
            .data      (data_q[i])
        );
    end

    assign pipe.out_valid = valid_q[STAGES-1];
    assign pipe.out_data  = data_q[STAGES-1];

    // Occupancy: popcount of registered valid bits plus the skid entry.
    always_comb begin
        occupancy = OCC_W'(skid_occ);
        for (int i = 0; i < int'(STAGES); i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    // A stalled exit item must stay put unless it is flushed.
    exit_hold_a : assert property (@(posedge clk) disable iff (!reset_n)
        (valid_q[STAGES-1] && !pipe.out_ready && !flush[STAGES-1])
        |=> (valid_q[STAGES-1] && $stable(data_q[STAGES-1])));

    // Occupancy never exceeds the stages plus one skid entry.
    occ_bound_a : assert property (@(posedge clk) disable iff (!reset_n)
        (int'(occupancy) <= int'(STAGES) + 1));

endmodule
